// File: rtl/spi_reg_peripheral_if.sv
// SPI pins plus the register file outputs of spi_reg_peripheral.
// The peripheral takes the slave modport; the SPI controller side takes master.
interface spi_reg_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       txn_done;

    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, txn_done
    );

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, txn_done
    );
endinterface

// File: rtl/spi_reg_peripheral.sv
// Mode-0 SPI write-only register peripheral: 16-bit frames {rw, addr[6:0], data[7:0]},
// oversampled in the clk domain and committed into five 8-bit registers on ncs rise.
module spi_reg_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic      clk,
    input  logic      rst,
    spi_reg_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DISCARD} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic                   r_sclk_d, r_ncs_d;
    state_t                 r_state;
    logic [4:0]             r_cnt;
    logic [15:0]            r_shift;
    logic [7:0]             r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;
    logic                   r_txn_done;

    logic w_sclk, w_copi, w_ncs;
    logic w_sclk_rise, w_ncs_fall, w_ncs_rise, w_commit;

    // Equal-depth chains keep sclk/copi/ncs aligned; ncs resets high so release is edge-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
        end else begin
            r_sclk_sync[0] <= bus.sclk;
            r_copi_sync[0] <= bus.copi;
            r_ncs_sync[0]  <= bus.ncs;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_copi_sync[i] <= r_copi_sync[i-1];
                r_ncs_sync[i]  <= r_ncs_sync[i-1];
            end
            r_sclk_d <= w_sclk;
            r_ncs_d  <= w_ncs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs & r_ncs_d;
    assign w_ncs_rise  = w_ncs & ~r_ncs_d;
    assign w_commit    = (r_cnt == 5'd16) && r_shift[15] && (r_shift[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_out_lo   <= '0;
            r_out_hi   <= '0;
            r_pwm_lo   <= '0;
            r_pwm_hi   <= '0;
            r_duty     <= '0;
            r_txn_done <= 1'b0;
        end else begin
            r_txn_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                SHIFT: begin
                    // Chip-select release wins over a coincident sclk edge.
                    if (w_ncs_rise) begin
                        r_state <= IDLE;
                        if (w_commit) begin
                            r_txn_done <= 1'b1;
                            case (r_shift[14:8])
                                7'h00:   r_out_lo <= r_shift[7:0];
                                7'h01:   r_out_hi <= r_shift[7:0];
                                7'h02:   r_pwm_lo <= r_shift[7:0];
                                7'h03:   r_pwm_hi <= r_shift[7:0];
                                7'h04:   r_duty   <= r_shift[7:0];
                                default: ;
                            endcase
                        end
                    end else if (w_sclk_rise) begin
                        if (r_cnt == 5'd16) begin
                            r_state <= DISCARD;
                        end else begin
                            r_shift <= {r_shift[14:0], w_copi};
                            r_cnt   <= r_cnt + 5'd1;
                        end
                    end
                end
                DISCARD: begin
                    if (w_ncs_rise) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.en_reg_out_7_0  = r_out_lo;
    assign bus.en_reg_out_15_8 = r_out_hi;
    assign bus.en_reg_pwm_7_0  = r_pwm_lo;
    assign bus.en_reg_pwm_15_8 = r_pwm_hi;
    assign bus.pwm_duty_cycle  = r_duty;
    assign bus.txn_done        = r_txn_done;
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboarded bench for spi_reg_peripheral: expected commits are queued when a frame
// is driven and popped by a monitor on each txn_done pulse.
module tb_spi_reg_peripheral;
    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    spi_reg_if bus_if ();

    spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    exp_t       sb_q[$];
    logic [7:0] exp_regs [5];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;

    function automatic logic [7:0] dut_reg(input int a);
        case (a)
            0:       return bus_if.en_reg_out_7_0;
            1:       return bus_if.en_reg_out_15_8;
            2:       return bus_if.en_reg_pwm_7_0;
            3:       return bus_if.en_reg_pwm_15_8;
            default: return bus_if.pwm_duty_cycle;
        endcase
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect a commit: update the reference model and queue the scoreboard entry.
    task automatic expect_wr(input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
        exp_regs[a] = d;
    endtask

    // Drop ncs and clock out nbits MSB first; bits beyond 16 are zero. ncs is left low.
    task automatic send_bits(input logic [15:0] f, input int nbits);
        bus_if.ncs = 1'b0;
        clks(3);
        for (int i = 0; i < nbits; i++) begin
            bus_if.copi = (i < 16) ? f[15-i] : 1'b0;
            clks(3);
            bus_if.sclk = 1'b1;
            clks(3);
            bus_if.sclk = 1'b0;
        end
        clks(3);
    endtask

    task automatic send_frame(input logic [15:0] f, input int nbits, input int gap);
        send_bits(f, nbits);
        bus_if.ncs = 1'b1;
        clks(gap);
    endtask

    // Monitor: every txn_done pulse must match the oldest queued commit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.txn_done === 1'b1) begin
                pulses++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_txn_done: txn_done=1 with no commit expected at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    if (dut_reg(e.addr) !== e.data) begin
                        errors++;
                        $display("FAIL commit_value addr %0d: got %h expected %h", e.addr, dut_reg(e.addr), e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        clks(3);
        for (int a = 0; a < 5; a++) begin
            checks++;
            if (dut_reg(a) !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected 00", a, dut_reg(a));
            end
        end
        checks++;
        if (bus_if.txn_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_txn_done: got %b expected 0", bus_if.txn_done);
        end
        rst = 1'b0;
        clks(4);
    endtask

    task automatic test_write_basic;
        expect_wr(3'd0, 8'hF0);
        send_frame(16'h80F0, 16, 8);
        for (int a = 0; a < 5; a++) begin
            checks++;
            if (dut_reg(a) !== exp_regs[a]) begin
                errors++;
                $display("FAIL basic_reg%0d: got %h expected %h", a, dut_reg(a), exp_regs[a]);
            end
        end
        checks++;
        if (sb_q.size() != 0 || pulses != 1) begin
            errors++;
            $display("FAIL basic_pulses: pending %0d pulses %0d expected 0 and 1", sb_q.size(), pulses);
        end
    endtask

    task automatic test_latency;
        expect_wr(3'd4, 8'h80);
        send_bits(16'h8480, 16);
        bus_if.ncs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.pwm_duty_cycle !== 8'h00 || bus_if.txn_done !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: duty %h done %b expected 00 and 0", bus_if.pwm_duty_cycle, bus_if.txn_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.pwm_duty_cycle !== 8'h80 || bus_if.txn_done !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge3: duty %h done %b expected 80 and 1", bus_if.pwm_duty_cycle, bus_if.txn_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.txn_done !== 1'b0) begin
            errors++;
            $display("FAIL latency_pulse_width: done %b expected 0", bus_if.txn_done);
        end
        clks(6);
        expect_wr(3'd3, 8'hA5);
        send_frame(16'h83A5, 16, 8);
        for (int a = 0; a < 5; a++) begin
            checks++;
            if (dut_reg(a) !== exp_regs[a]) begin
                errors++;
                $display("FAIL latency_reg%0d: got %h expected %h", a, dut_reg(a), exp_regs[a]);
            end
        end
    endtask

    task automatic test_ignored_frames;
        int p0;
        p0 = pulses;
        send_frame(16'h0055, 16, 8);
        send_frame(16'h8555, 16, 8);
        send_frame(16'h81FF, 15, 8);
        send_frame(16'h81FF, 17, 8);
        for (int a = 0; a < 5; a++) begin
            checks++;
            if (dut_reg(a) !== exp_regs[a]) begin
                errors++;
                $display("FAIL ignored_reg%0d: got %h expected %h", a, dut_reg(a), exp_regs[a]);
            end
        end
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL ignored_pulses: got %0d expected 0", pulses - p0);
        end
        expect_wr(3'd1, 8'hFF);
        send_frame(16'h81FF, 16, 8);
        checks++;
        if (bus_if.en_reg_out_15_8 !== 8'hFF || sb_q.size() != 0) begin
            errors++;
            $display("FAIL length_recover: got %h pending %0d expected FF and 0", bus_if.en_reg_out_15_8, sb_q.size());
        end
    endtask

    task automatic test_reset_midframe;
        expect_wr(3'd2, 8'h33);
        send_frame(16'h8233, 16, 8);
        send_bits(16'h82CC, 8);
        rst = 1'b1;
        for (int a = 0; a < 5; a++) exp_regs[a] = 8'h00;
        clks(2);
        bus_if.ncs = 1'b1;
        bus_if.copi = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(4);
        for (int a = 0; a < 5; a++) begin
            checks++;
            if (dut_reg(a) !== 8'h00) begin
                errors++;
                $display("FAIL midrst_reg%0d: got %h expected 00", a, dut_reg(a));
            end
        end
        expect_wr(3'd2, 8'h77);
        send_frame(16'h8277, 16, 8);
        checks++;
        if (bus_if.en_reg_pwm_7_0 !== 8'h77 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_recover: got %h pending %0d expected 77 and 0", bus_if.en_reg_pwm_7_0, sb_q.size());
        end
    endtask

    task automatic test_sclk_idle;
        int p0;
        p0 = pulses;
        expect_wr(3'd0, 8'h11);
        send_frame(16'h8011, 16, 4);
        for (int i = 0; i < 12; i++) begin
            bus_if.copi = 1'($urandom_range(0, 1));
            clks(3);
            bus_if.sclk = ~bus_if.sclk;
        end
        bus_if.sclk = 1'b0;
        clks(4);
        expect_wr(3'd1, 8'h22);
        send_frame(16'h8122, 16, 8);
        checks++;
        if (pulses - p0 != 2 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL idle_sclk_pulses: got %0d pending %0d expected 2 and 0", pulses - p0, sb_q.size());
        end
        for (int a = 0; a < 5; a++) begin
            checks++;
            if (dut_reg(a) !== exp_regs[a]) begin
                errors++;
                $display("FAIL idle_sclk_reg%0d: got %h expected %h", a, dut_reg(a), exp_regs[a]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        for (int a = 0; a < 5; a++) begin
            d = 8'($urandom_range(0, 255));
            expect_wr(3'(a), d);
            send_frame({1'b1, 7'(a), d}, 16, 3);
        end
        clks(6);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d expected 0", sb_q.size());
        end
        for (int a = 0; a < 5; a++) begin
            checks++;
            if (dut_reg(a) !== exp_regs[a]) begin
                errors++;
                $display("FAIL b2b_reg%0d: got %h expected %h", a, dut_reg(a), exp_regs[a]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.sclk = 1'b0;
        bus_if.copi = 1'b0;
        bus_if.ncs  = 1'b1;
        for (int a = 0; a < 5; a++) exp_regs[a] = 8'h00;
        test_reset();
        test_write_basic();
        test_latency();
        test_ignored_frames();
        test_reset_midframe();
        test_sclk_idle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_peripheral.md
SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers on sclk, copi and ncs.
REQ-002 Parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 copi  input  1  SPI controller-out/peripheral-in data, asynchronous to clk.
REQ-007 ncs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-008 en_reg_out_7_0  output  8  register at address 0x00.
REQ-009 en_reg_out_15_8  output  8  register at address 0x01.
REQ-010 en_reg_pwm_7_0  output  8  register at address 0x02.
REQ-011 en_reg_pwm_15_8  output  8  register at address 0x03.
REQ-012 pwm_duty_cycle  output  8  register at address 0x04.
REQ-013 txn_done  output  1  one-clk pulse marking each committed write.

Function
REQ-014 The block SHALL pass sclk, copi and ncs through SYNC_STAGES-deep synchronizers of equal depth, so the three signals stay mutually aligned.
REQ-015 All edge detection SHALL compare the last synchronizer stage with one further registered copy.
REQ-016 The SPI mode SHALL be mode 0: copi is sampled on each detected sclk rising edge while synced ncs=0; sclk falling edges are ignored.
REQ-017 Clock ratio: sclk high and low phases SHALL each be at least 2 clk periods; behaviour at faster sclk is undefined.
REQ-018 The frame SHALL be 16 bits, MSB first: bit15 R/W (1=write), bits14:8 address, bits7:0 data.
REQ-019 The FSM SHALL have the states IDLE (ncs high), SHIFT (ncs low, counting bits) and DISCARD (more than 16 bits seen).
REQ-020 Transitions:
- IDLE->SHIFT on the detected ncs falling edge; the 5-bit counter and the 16-bit shift register clear.
- SHIFT->DISCARD on the 17th sclk rising edge.
- SHIFT->IDLE and DISCARD->IDLE on the detected ncs rising edge.
REQ-021 On the ncs rising edge from SHIFT, a commit SHALL occur only if count==16, R/W==1 and address<=MAX_ADDR.
REQ-022 A commit SHALL write the data byte into the addressed register and pulse txn_done high for exactly 1 clk.
REQ-023 Read frames, short frames, frames from DISCARD, and frames with address>MAX_ADDR SHALL leave all registers unchanged and SHALL NOT pulse txn_done.
REQ-024 Commit latency: with SYNC_STAGES=2, the register and txn_done SHALL update on the 3rd clk rising edge, counting the first edge that samples raw ncs=1.
REQ-025 sclk edges while ncs is high SHALL be ignored; the counter and shift register hold.
REQ-026 Back-to-back frames with ncs high for at least 2 clk SHALL each commit independently.
REQ-027 Registers SHALL hold their values indefinitely between commits.

Reset
REQ-028 While rst=1, all five registers SHALL be 8'h00, txn_done 0, the FSM in IDLE, the counter 0, and the shift register 0.
REQ-029 Synchronizer flops SHALL reset to 1 on ncs and to 0 on sclk/copi, so that release from reset causes no false edge.
REQ-030 A reset asserted mid-frame SHALL abort the frame without commit; after release, the first complete frame SHALL commit normally.

Verification
REQ-031 Write frame 16'h80F0 -> en_reg_out_7_0=8'hF0, txn_done pulses once, other registers stay 8'h00.
REQ-032 Write frame 16'h8480 -> pwm_duty_cycle=8'h80 at the REQ-024 latency; then write 16'h83A5 -> en_reg_pwm_15_8=8'hA5, pwm_duty_cycle still 8'h80.
REQ-033 Read frame 16'h0055 and write frame 16'h8555 (address 0x05) -> all registers unchanged, no txn_done.
REQ-034 Write frame 16'h81FF truncated to 15 bits, then 16'h81FF extended to 17 bits -> en_reg_out_15_8 stays 8'h00; a following correct 16'h81FF -> 8'hFF.
REQ-035 Write 16'h8233 complete; assert rst after 8 bits of frame 16'h82CC -> en_reg_pwm_7_0=8'h00; after release, frame 16'h8277 -> 8'h77.
REQ-036 Toggle sclk with ncs high between two valid frames -> only the two framed writes commit, with exactly two txn_done pulses.
